// File: rtl/traffic_display_scan_pkg.sv
// Shared constants and types for the traffic-light display scanner:
// active-low segment patterns, digit positions, display modes and the
// frame shadow record.
package traffic_display_pkg;

  // Segment patterns, {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit positions: side A on digits 1:0, side B on digits 3:2.
  localparam logic [1:0] DIG_A_L = 2'd0;
  localparam logic [1:0] DIG_A_H = 2'd1;
  localparam logic [1:0] DIG_B_L = 2'd2;
  localparam logic [1:0] DIG_B_H = 2'd3;

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_OVERRIDE,
    MODE_IDLE
  } mode_t;

  // Inputs captured once per frame so a frame never mixes old and new values.
  typedef struct packed {
    logic [3:0] bcd_h;
    logic [3:0] bcd_l;
    logic       light_a;
    logic       light_b;
    logic       police;
  } shadow_t;

  // Police override wins; otherwise exactly one green request is a legal
  // running state and anything else falls back to the idle display.
  function automatic mode_t get_mode(input shadow_t s);
    if (s.police)                  return MODE_OVERRIDE;
    else if (s.light_a ^ s.light_b) return MODE_NORMAL;
    else                           return MODE_IDLE;
  endfunction

endpackage

// File: rtl/traffic_display_scan_if.sv
// Signal bundle between the light interface (master) and the display
// scanner (slave): countdown/flags inbound, display and lamp drive outbound.
interface traffic_display_scan_if;
  logic [3:0] bcd_h;
  logic [3:0] bcd_l;
  logic       light_a;
  logic       light_b;
  logic       police;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       lamp_a_grn;
  logic       lamp_a_red;
  logic       lamp_b_grn;
  logic       lamp_b_red;
  logic       frame_tick;

  modport master (
    output bcd_h, bcd_l, light_a, light_b, police,
    input  seg_n, an_n, lamp_a_grn, lamp_a_red, lamp_b_grn, lamp_b_red,
           frame_tick
  );

  modport slave (
    input  bcd_h, bcd_l, light_a, light_b, police,
    output seg_n, an_n, lamp_a_grn, lamp_a_red, lamp_b_grn, lamp_b_red,
           frame_tick
  );
endinterface

// File: rtl/traffic_display_scan_seg7_decode.sv
// BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module seg7_decode
  import traffic_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  // Pure lookup, no state.
  always_comb begin
    seg_n_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_n_o = SEG_0;
      4'd1:    seg_n_o = SEG_1;
      4'd2:    seg_n_o = SEG_2;
      4'd3:    seg_n_o = SEG_3;
      4'd4:    seg_n_o = SEG_4;
      4'd5:    seg_n_o = SEG_5;
      4'd6:    seg_n_o = SEG_6;
      4'd7:    seg_n_o = SEG_7;
      4'd8:    seg_n_o = SEG_8;
      4'd9:    seg_n_o = SEG_9;
      default: seg_n_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/traffic_display_scan.sv
// Four-digit multiplexed display and lamp driver for the traffic-light
// controller. Inputs are latched into a shadow record at each frame start;
// every output is registered. Optional build macro LEADING_ZERO_BLANK_EN
// blanks the tens digits in normal mode when the tens value is zero.
module traffic_display_scan
  import traffic_display_pkg::*;
#(
  parameter int SCAN_DIV   = 4,  // clk cycles per digit, >= 2
  parameter int BLINK_HALF = 8   // frames per blink half-period, >= 1
) (
  input logic               clk,
  input logic               reset_n,
  traffic_display_scan_if.slave dsp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_HALF - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          pend_q;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  shadow_t       sh_q, sh_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    lamp_q, lamp_d;   // {a_grn, a_red, b_grn, b_red}
  logic          tick_q;
  logic          frame_start, adv;
  logic [3:0]    dig_sel;
  logic [6:0]    dec_seg;
  mode_t         mode;

  // Scan timing: prescaler, digit pointer, frame start, shadow and blink.
  always_comb begin
    presc_d     = presc_q;
    ptr_d       = ptr_q;
    sh_d        = sh_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    frame_start = 1'b0;
    adv         = 1'b0;
    if (pend_q) begin
      // First edge after reset release enters digit 0 immediately.
      frame_start = 1'b1;
      adv         = 1'b1;
      ptr_d       = DIG_A_L;
      presc_d     = '0;
    end else if (presc_q == PRESC_TC) begin
      presc_d     = '0;
      adv         = 1'b1;
      ptr_d       = ptr_q + 2'd1;
      frame_start = (ptr_q == DIG_B_H);
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (frame_start) begin
      sh_d = '{bcd_h:   dsp.bcd_h,
               bcd_l:   dsp.bcd_l,
               light_a: dsp.light_a,
               light_b: dsp.light_b,
               police:  dsp.police};
      if (blink_cnt_q == BLINK_TC) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    mode    = get_mode(sh_d);
    dig_sel = ptr_d[0] ? sh_d.bcd_h : sh_d.bcd_l;
  end

  seg7_decode u_dec (
    .bcd_i   (dig_sel),
    .seg_n_o (dec_seg)
  );

  // Next display/lamp values for the digit being entered.
  always_comb begin
    seg_d  = SEG_BLANK;
    an_d   = 4'hF;
    lamp_d = 4'b0000;
    case (mode)
      MODE_OVERRIDE: seg_d = SEG_F;
      MODE_NORMAL: begin
        seg_d = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if (ptr_d[0] && (sh_d.bcd_h == 4'd0)) seg_d = SEG_BLANK;
`endif
      end
      default: seg_d = SEG_DASH;
    endcase
    case (ptr_d)
      DIG_A_L: an_d = 4'b1110;
      DIG_A_H: an_d = 4'b1101;
      DIG_B_L: an_d = 4'b1011;
      DIG_B_H: an_d = 4'b0111;
      default: an_d = 4'hF;
    endcase
    // Lamps depend only on the light flags; override keeps the green side.
    if (sh_d.light_a ^ sh_d.light_b)
      lamp_d = {sh_d.light_a, ~sh_d.light_a, sh_d.light_b, ~sh_d.light_b};
    else
      lamp_d = {1'b0, blink_d, 1'b0, blink_d};
  end

  // State and output registers; display only updates on pointer advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      ptr_q       <= DIG_A_L;
      pend_q      <= 1'b1;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      sh_q        <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'hF;
      lamp_q      <= 4'b0000;
      tick_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      ptr_q       <= ptr_d;
      pend_q      <= 1'b0;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      sh_q        <= sh_d;
      lamp_q      <= lamp_d;
      tick_q      <= frame_start;
      if (adv) begin
        seg_q <= seg_d;
        an_q  <= an_d;
      end
    end
  end

  assign dsp.seg_n      = seg_q;
  assign dsp.an_n       = an_q;
  assign dsp.lamp_a_grn = lamp_q[3];
  assign dsp.lamp_a_red = lamp_q[2];
  assign dsp.lamp_b_grn = lamp_q[1];
  assign dsp.lamp_b_red = lamp_q[0];
  assign dsp.frame_tick = tick_q;

endmodule

// File: tb/tb_traffic_display_scan.sv
// Scoreboard bench for traffic_display_scan: the stimulus process pushes the
// expected {an_n, seg_n, lamps, frame_tick} for every digit of each frame;
// the monitor pops and compares whenever the active anode changes.
module tb_traffic_display_scan;
  import traffic_display_pkg::*;

  localparam int SCAN_DIV   = 4;
  localparam int BLINK_HALF = 8;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  traffic_display_scan_if dif ();

  traffic_display_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dsp     (dif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int frame_no;

  // One directed vector: inputs, frames held, hand-decoded segments for
  // the units/tens digits, lamps {a_grn,a_red,b_grn,b_red}; idle=1 means
  // both reds follow the blink phase instead.
  typedef struct {
    logic [3:0] bh;
    logic [3:0] bl;
    logic       la;
    logic       lb;
    logic       pol;
    int         nfr;
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;
    logic [3:0] lamps;
    logic       idle;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1, 7'h12, 7'h24, 4'b1001, 1'b0};
    vecs[1] = '{4'd1, 4'd9, 1'b1, 1'b0, 1'b0, 1, 7'h10, 7'h79, 4'b1001, 1'b0};
    vecs[2] = '{4'd1, 4'd9, 1'b0, 1'b1, 1'b1, 1, 7'h0E, 7'h0E, 4'b0110, 1'b0};
    vecs[3] = '{4'd1, 4'd9, 1'b0, 1'b0, 1'b0, 6, 7'h3F, 7'h3F, 4'b0000, 1'b1};
    vecs[4] = '{4'd3, 4'd6, 1'b1, 1'b1, 1'b0, 8, 7'h3F, 7'h3F, 4'b0000, 1'b1};
    vecs[5] = '{4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 1, 7'h78, LZ_SEG, 4'b1001, 1'b0};
    vecs[6] = '{4'd3, 4'hC, 1'b0, 1'b1, 1'b0, 1, 7'h3F, 7'h30, 4'b0110, 1'b0};
    vecs[7] = '{4'd0, 4'd7, 1'b0, 1'b1, 1'b1, 1, 7'h0E, 7'h0E, 4'b0110, 1'b0};
    vecs[8] = '{4'd4, 4'd8, 1'b1, 1'b0, 1'b0, 1, 7'h00, 7'h19, 4'b1001, 1'b0};
    vecs[9] = '{4'd6, 4'd0, 1'b0, 1'b1, 1'b0, 2, 7'h40, 7'h02, 4'b0110, 1'b0};
  end

  function automatic logic [15:0] actual();
    return {dif.an_n, dif.seg_n, dif.lamp_a_grn, dif.lamp_a_red,
            dif.lamp_b_grn, dif.lamp_b_red, dif.frame_tick};
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input int vi);
    dif.bcd_h   = vecs[vi].bh;
    dif.bcd_l   = vecs[vi].bl;
    dif.light_a = vecs[vi].la;
    dif.light_b = vecs[vi].lb;
    dif.police  = vecs[vi].pol;
  endtask

  // Blink phase seen during frame f (1-based since reset release): it
  // flips at the start of every BLINK_HALF-th frame.
  task automatic push_frame(input int vi, input int f);
    logic [3:0] lamps;
    logic       ph;
    logic [3:0] an;
    logic [6:0] seg;
    ph    = ((f / BLINK_HALF) % 2) == 1;
    lamps = vecs[vi].idle ? {1'b0, ph, 1'b0, ph} : vecs[vi].lamps;
    for (int k = 0; k < 4; k++) begin
      an  = ~(4'b0001 << k);
      seg = (k % 2 == 1) ? vecs[vi].seg_hi : vecs[vi].seg_lo;
      exp_q.push_back({an, seg, lamps, (k == 0)});
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (dif.frame_tick) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_frame no frame_tick within 100 cycles");
    end
  endtask

  // Monitor: compares on each anode change, and checks digit dwell time and
  // that frame_tick stays low between advances.
  initial begin
    logic [3:0]  prev_an;
    logic [15:0] e;
    int          cyc;
    bit          first;
    prev_an = 4'hF;
    cyc     = 0;
    first   = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_an = 4'hF;
        first   = 1'b1;
        cyc     = 0;
      end else begin
        cyc++;
        if (dif.an_n !== prev_an) begin
          if (!first) chk("digit_dwell", 16'(cyc), 16'(SCAN_DIV));
          first = 1'b0;
          cyc   = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_digit actual=%h expected=none", actual());
          end else begin
            e = exp_q.pop_front();
            chk("digit_out", actual(), e);
          end
          prev_an = dif.an_n;
        end else begin
          chk("tick_low", {15'd0, dif.frame_tick}, 16'd0);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    apply(0);
    #1 reset_n = 1'b0;
    #22;
    chk("reset_state", actual(), {4'hF, 7'h7F, 4'b0000, 1'b0});
    frame_no = 1;
    push_frame(0, frame_no);
    @(negedge clk);
    reset_n = 1'b1;

    // Each new vector is applied just after a frame start, i.e. mid-frame,
    // so it must only show up from the following frame.
    for (int vi = 1; vi <= 8; vi++) begin
      for (int n = 0; n < vecs[vi].nfr; n++) begin
        wait_frame();
        frame_no++;
        apply(vi);
        push_frame(vi, frame_no);
      end
    end

    // Frame with vector 8 starts; interrupt it while digit 2 is shown.
    wait_frame();
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1 chk("async_reset", actual(), {4'hF, 7'h7F, 4'b0000, 1'b0});
    apply(9);
    frame_no = 1;
    push_frame(9, frame_no);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_frame();
    frame_no++;
    push_frame(9, frame_no);
    wait_frame();
    repeat (13) @(negedge clk);
    chk("queue_drain", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
